ad7528_att_writer: RTL and testbench

AD7528_ATT_WRITER -- requirements
Module: ad7528_att_writer

---
 rtl/ad7528_att_writer.sv | 188 ++++++++++++++++++
 tb/tb_ad7528_att_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ad7528_att_writer.sv
// Serial attenuation-code writer for two AD7528 devices: latches one request and
// shifts a 9-bit MSB-first frame on clkdac/datadac under the selected chip select.
module ad7528_att_writer #(
    parameter int HALF_PERIOD = 15,
    parameter int GAP         = 4
) (
    input  logic       clk30,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_dac,
    input  logic       req_sel,
    input  logic [7:0] req_data,
    output logic       datadac,
    output logic       clkdac,
    output logic       csdac1n,
    output logic       csdac2n,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_SHIFT_HI = 3'd2,
        S_SHIFT_LO = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    localparam logic [7:0] HP_RELOAD  = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] GAP_RELOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    state_t     state_r, state_s;
    logic [7:0] hp_cnt_r, hp_cnt_s;
    logic [3:0] bit_cnt_r, bit_cnt_s;
    logic [7:0] gap_cnt_r, gap_cnt_s;
    logic [7:0] shreg_r, shreg_s;
    logic       datadac_r, datadac_s;
    logic       clkdac_r, clkdac_s;
    logic       cs1n_r, cs1n_s;
    logic       cs2n_r, cs2n_s;
    logic       ready_r, ready_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        state_s   = state_r;
        hp_cnt_s  = hp_cnt_r;
        bit_cnt_s = bit_cnt_r;
        gap_cnt_s = gap_cnt_r;
        shreg_s   = shreg_r;
        datadac_s = datadac_r;
        clkdac_s  = clkdac_r;
        cs1n_s    = cs1n_r;
        cs2n_s    = cs2n_r;
        ready_s   = ready_r;
        busy_s    = busy_r;
        done_s    = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (req_valid && ready_r) begin
                    state_s   = S_SETUP;
                    hp_cnt_s  = HP_RELOAD;
                    bit_cnt_s = 4'd0;
                    shreg_s   = req_data;
                    datadac_s = req_sel;
                    clkdac_s  = 1'b0;
                    cs1n_s    = req_dac;
                    cs2n_s    = ~req_dac;
                    ready_s   = 1'b0;
                    busy_s    = 1'b1;
                end else begin
                    ready_s   = 1'b1;
                end
            end
            S_SETUP: begin
                if (hp_cnt_r == 8'd0) begin
                    state_s  = S_SHIFT_HI;
                    hp_cnt_s = HP_RELOAD;
                    clkdac_s = 1'b1;
                end else begin
                    hp_cnt_s = hp_cnt_r - 8'd1;
                end
            end
            S_SHIFT_HI: begin
                if (hp_cnt_r == 8'd0) begin
                    state_s  = S_SHIFT_LO;
                    hp_cnt_s = HP_RELOAD;
                    clkdac_s = 1'b0;
                    // The last bit stays on the line through the hold phase.
                    if (bit_cnt_r != 4'd8) begin
                        datadac_s = shreg_r[7];
                        shreg_s   = {shreg_r[6:0], 1'b0};
                    end else begin
                        datadac_s = datadac_r;
                    end
                end else begin
                    hp_cnt_s = hp_cnt_r - 8'd1;
                end
            end
            S_SHIFT_LO: begin
                if (hp_cnt_r == 8'd0) begin
                    if (bit_cnt_r == 4'd8) begin
                        cs1n_s    = 1'b1;
                        cs2n_s    = 1'b1;
                        datadac_s = 1'b0;
                        done_s    = 1'b1;
                        if (GAP == 0) begin
                            state_s = S_IDLE;
                            ready_s = 1'b1;
                            busy_s  = 1'b0;
                        end else begin
                            state_s   = S_GAP;
                            gap_cnt_s = GAP_RELOAD;
                        end
                    end else begin
                        state_s   = S_SHIFT_HI;
                        hp_cnt_s  = HP_RELOAD;
                        bit_cnt_s = bit_cnt_r + 4'd1;
                        clkdac_s  = 1'b1;
                    end
                end else begin
                    hp_cnt_s = hp_cnt_r - 8'd1;
                end
            end
            S_GAP: begin
                if (gap_cnt_r == 8'd0) begin
                    state_s = S_IDLE;
                    ready_s = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    gap_cnt_s = gap_cnt_r - 8'd1;
                end
            end
            default: begin
                state_s   = S_IDLE;
                cs1n_s    = 1'b1;
                cs2n_s    = 1'b1;
                clkdac_s  = 1'b0;
                datadac_s = 1'b0;
                ready_s   = 1'b0;
                busy_s    = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk30) begin
        if (reset) begin
            state_r   <= S_IDLE;
            hp_cnt_r  <= 8'd0;
            bit_cnt_r <= 4'd0;
            gap_cnt_r <= 8'd0;
            shreg_r   <= 8'd0;
            datadac_r <= 1'b0;
            clkdac_r  <= 1'b0;
            cs1n_r    <= 1'b1;
            cs2n_r    <= 1'b1;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            hp_cnt_r  <= hp_cnt_s;
            bit_cnt_r <= bit_cnt_s;
            gap_cnt_r <= gap_cnt_s;
            shreg_r   <= shreg_s;
            datadac_r <= datadac_s;
            clkdac_r  <= clkdac_s;
            cs1n_r    <= cs1n_s;
            cs2n_r    <= cs2n_s;
            ready_r   <= ready_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign req_ready = ready_r;
    assign datadac   = datadac_r;
    assign clkdac    = clkdac_r;
    assign csdac1n   = cs1n_r;
    assign csdac2n   = cs2n_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_ad7528_att_writer.sv
// Directed bench for ad7528_att_writer: a default instance (H=15, GAP=4) driven from
// a vector table plus corner sequences, and a fast instance (H=1, GAP=0).
module tb_ad7528_att_writer;

    localparam int H = 15;
    localparam int G = 4;

    logic clk30 = 1'b0;
    logic reset = 1'b1;

    logic       a_valid = 1'b0, a_dac = 1'b0, a_sel = 1'b0;
    logic [7:0] a_data = 8'd0;
    logic       a_ready, a_dd, a_ck, a_cs1, a_cs2, a_busy, a_done;
    logic       b_valid = 1'b0, b_dac = 1'b0, b_sel = 1'b0;
    logic [7:0] b_data = 8'd0;
    logic       b_ready, b_dd, b_ck, b_cs1, b_cs2, b_busy, b_done;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    ad7528_att_writer #(.HALF_PERIOD(H), .GAP(G)) dut_a (
        .clk30(clk30), .reset(reset), .req_valid(a_valid), .req_ready(a_ready),
        .req_dac(a_dac), .req_sel(a_sel), .req_data(a_data), .datadac(a_dd),
        .clkdac(a_ck), .csdac1n(a_cs1), .csdac2n(a_cs2), .busy(a_busy), .done(a_done)
    );

    ad7528_att_writer #(.HALF_PERIOD(1), .GAP(0)) dut_b (
        .clk30(clk30), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
        .req_dac(b_dac), .req_sel(b_sel), .req_data(b_data), .datadac(b_dd),
        .clkdac(b_ck), .csdac1n(b_cs1), .csdac2n(b_cs2), .busy(b_busy), .done(b_done)
    );

    always #5 clk30 = ~clk30;

    always @(posedge clk30) cyc <= cyc + 1;

    // Receiver models: sample datadac on clkdac rising edges and count cs-low cycles.
    int a_nbits = 0, a_low1 = 0, a_low2 = 0, a_hi = 0, a_both = 0, a_stab = 0;
    logic [8:0] a_bits = 9'd0;
    logic a_pck = 1'b0, a_pdd = 1'b0, a_pcs = 1'b0;
    int b_nbits = 0, b_low1 = 0, b_low2 = 0, b_hi = 0, b_both = 0, b_stab = 0;
    logic [8:0] b_bits = 9'd0;
    logic b_pck = 1'b0, b_pdd = 1'b0, b_pcs = 1'b0;

    always @(negedge clk30) begin
        if (!a_cs1) a_low1++;
        if (!a_cs2) a_low2++;
        if (!a_cs1 && !a_cs2) a_both++;
        if (a_ck) a_hi++;
        if (a_ck && !a_pck) begin a_bits = {a_bits[7:0], a_dd}; a_nbits++; end
        if (a_pcs && (!a_cs1 || !a_cs2) && (a_dd !== a_pdd) && !(a_pck && !a_ck)) a_stab++;
        a_pck = a_ck; a_pdd = a_dd; a_pcs = !a_cs1 || !a_cs2;

        if (!b_cs1) b_low1++;
        if (!b_cs2) b_low2++;
        if (!b_cs1 && !b_cs2) b_both++;
        if (b_ck) b_hi++;
        if (b_ck && !b_pck) begin b_bits = {b_bits[7:0], b_dd}; b_nbits++; end
        if (b_pcs && (!b_cs1 || !b_cs2) && (b_dd !== b_pdd) && !(b_pck && !b_ck)) b_stab++;
        b_pck = b_ck; b_pdd = b_dd; b_pcs = !b_cs1 || !b_cs2;
    end

    task automatic step;
        @(posedge clk30);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_a;
        a_nbits = 0; a_low1 = 0; a_low2 = 0; a_hi = 0; a_bits = 9'd0;
    endtask

    task automatic clr_b;
        b_nbits = 0; b_low1 = 0; b_low2 = 0; b_hi = 0; b_bits = 9'd0;
    endtask

    task automatic wait_a_ready;
        int n;
        n = 0;
        while (!a_ready && n < 2000) begin step(); n++; end
        chk("a_ready_wait", a_ready, 1);
    endtask

    task automatic wait_a_done;
        int n;
        n = 0;
        while (!a_done && n < 2000) begin step(); n++; end
        chk("a_done_wait", a_done, 1);
    endtask

    // One frame on instance A, inputs scrambled the cycle after accept.
    task automatic send_a(input logic dac, input logic sel, input logic [7:0] data,
                          input logic [8:0] exp);
        int ka;
        wait_a_ready();
        clr_a();
        a_dac = dac; a_sel = sel; a_data = data; a_valid = 1'b1;
        step();
        ka = cyc;
        a_valid = 1'b0;
        chk("busy_after_accept", a_busy, 1);
        chk("ready_low_after_accept", a_ready, 0);
        chk("sel_cs_low_first_cycle", dac ? a_cs2 : a_cs1, 0);
        chk("first_bit_setup", a_dd, exp[8]);
        step();
        a_dac = ~dac; a_sel = ~sel; a_data = ~data;
        wait_a_done();
        chk("done_latency", cyc - ka, 19 * H);
        chk("cs_high_at_done", a_cs1 & a_cs2, 1);
        chk("data_zero_at_done", a_dd, 0);
        step();
        chk("done_one_cycle", a_done, 0);
        wait_a_ready();
        chk("ready_latency", cyc - ka, 19 * H + G);
        chk("busy_clear_at_ready", a_busy, 0);
        chk("frame_bits", a_bits, exp);
        chk("frame_nbits", a_nbits, 9);
        chk("sel_cs_low_cycles", dac ? a_low2 : a_low1, 19 * H);
        chk("other_cs_low_cycles", dac ? a_low1 : a_low2, 0);
    endtask

    typedef struct {
        logic       dac;
        logic       sel;
        logic [7:0] data;
        logic [8:0] exp;
    } vec_t;

    vec_t vt[5];

    initial begin
        int n;
        int dn;
        int kb;
        vt[0] = '{dac: 1'b0, sel: 1'b1, data: 8'hA5, exp: 9'h1A5};
        vt[1] = '{dac: 1'b1, sel: 1'b0, data: 8'h00, exp: 9'h000};
        vt[2] = '{dac: 1'b0, sel: 1'b0, data: 8'hFF, exp: 9'h0FF};
        vt[3] = '{dac: 1'b1, sel: 1'b1, data: 8'h3C, exp: 9'h13C};
        vt[4] = '{dac: 1'b0, sel: 1'b1, data: 8'h01, exp: 9'h101};

        // Reset values, then ready on the first cycle after release.
        step(); step(); step();
        chk("rst_datadac", a_dd, 0);
        chk("rst_clkdac", a_ck, 0);
        chk("rst_cs1", a_cs1, 1);
        chk("rst_cs2", a_cs2, 1);
        chk("rst_ready", a_ready, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        reset = 1'b0;
        step();
        chk("ready_after_reset", a_ready, 1);
        chk("ready_after_reset_b", b_ready, 1);

        for (int i = 0; i < 5; i++) begin
            send_a(vt[i].dac, vt[i].sel, vt[i].data, vt[i].exp);
        end

        // Back-to-back with req_valid held high.
        wait_a_ready();
        clr_a();
        a_dac = 1'b0; a_sel = 1'b0; a_data = 8'hFF; a_valid = 1'b1;
        step();
        chk("b2b_first_accept", a_busy, 1);
        a_data = 8'h01;
        wait_a_done();
        n = 0;
        while (a_cs1 && n < 50) begin n++; step(); end
        chk("b2b_cs_high_cycles", n, G + 1);
        chk("b2b_first_bits", a_bits, 9'h0FF);
        clr_a();
        a_valid = 1'b0;
        wait_a_done();
        chk("b2b_second_bits", a_bits, 9'h001);
        chk("b2b_second_nbits", a_nbits, 9);

        // Reset during bit 4 aborts without a done pulse.
        wait_a_ready();
        clr_a();
        a_dac = 1'b1; a_sel = 1'b1; a_data = 8'h5A; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        n = 0;
        while (a_nbits < 5 && n < 2000) begin step(); n++; end
        chk("abort_reached_bit4", a_nbits, 5);
        reset = 1'b1;
        step();
        chk("abort_cs1", a_cs1, 1);
        chk("abort_cs2", a_cs2, 1);
        chk("abort_clk", a_ck, 0);
        chk("abort_done", a_done, 0);
        reset = 1'b0;
        dn = 0;
        repeat (20 * H) begin step(); if (a_done) dn++; end
        chk("abort_no_done", dn, 0);
        send_a(1'b0, 1'b0, 8'h3C, 9'h03C);

        // Fast instance: H=1, GAP=0, accept right after done.
        clr_b();
        b_dac = 1'b1; b_sel = 1'b1; b_data = 8'h81; b_valid = 1'b1;
        step();
        kb = cyc;
        b_sel = 1'b0; b_data = 8'h55;
        n = 0;
        while (!b_done && n < 200) begin step(); n++; end
        chk("fast_done_latency", cyc - kb, 19);
        chk("fast_ready_with_done", b_ready, 1);
        chk("fast_bits", b_bits, 9'h181);
        chk("fast_nbits", b_nbits, 9);
        chk("fast_cs2_low", b_low2, 19);
        chk("fast_cs1_low", b_low1, 0);
        chk("fast_clk_high_cycles", b_hi, 9);
        step();
        chk("fast_reaccept_busy", b_busy, 1);
        chk("fast_reaccept_cs2", b_cs2, 0);
        clr_b();
        b_valid = 1'b0;
        n = 0;
        while (!b_done && n < 200) begin step(); n++; end
        chk("fast_second_bits", b_bits, 9'h055);
        chk("fast_second_cs2_low", b_low2, 19);

        chk("never_both_cs_low", a_both + b_both, 0);
        chk("data_change_only_on_fall", a_stab + b_stab, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
